// File: rtl/analog_filter_mc.sv
// Multi-channel N-sample moving-average filter with bypass; result 2 cycles after acceptance.
// One sample per cycle, no backpressure; clear flushes all channel state and in-flight samples.
module analog_filter_mc #(
  parameter int CHANNELS     = 4,
  parameter int DATA_W       = 12,
  parameter int LOG2_SAMPLES = 3,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                mode,
  input  logic                clear,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [DATA_W-1:0]   out_data,
  output logic [CHANNELS-1:0] primed
);

  localparam int N      = 1 << LOG2_SAMPLES;
  localparam int NSLOT  = 1 << CH_W;
  localparam int SUM_W  = DATA_W + LOG2_SAMPLES;
  localparam int FILL_W = LOG2_SAMPLES + 1;

  logic [SUM_W-1:0]        sum_q  [NSLOT];
  logic [LOG2_SAMPLES-1:0] wptr_q [NSLOT];
  logic [FILL_W-1:0]       fill_q [NSLOT];
  logic [CHANNELS-1:0]     primed_q;
  logic [DATA_W-1:0]       hist_q [NSLOT*N];

  logic                    s0_vld_q, s0_mode_q;
  logic [CH_W-1:0]         s0_ch_q;
  logic [DATA_W-1:0]       s0_data_q;

  logic                    s1_vld_q, s1_mode_q;
  logic [CH_W-1:0]         s1_ch_q;
  logic [DATA_W-1:0]       s1_data_q, s1_old_q;
  logic [SUM_W-1:0]        s1_sum_q;
  logic [FILL_W-1:0]       s1_fill_q;
  logic [LOG2_SAMPLES-1:0] s1_ptr_q;

  logic                    out_valid_q;
  logic [CH_W-1:0]         out_ch_q;
  logic [DATA_W-1:0]       out_data_q;

  logic                    accept;
  logic                    full;
  logic [SUM_W-1:0]        sum_d;
  logic [FILL_W-1:0]       fill_d;
  logic [LOG2_SAMPLES-1:0] ptr_d;
  logic                    fwd;
  logic [SUM_W-1:0]        rd_sum;
  logic [FILL_W-1:0]       rd_fill;
  logic [LOG2_SAMPLES-1:0] rd_ptr;
  logic [DATA_W-1:0]       rd_old;

  assign accept = in_valid && !clear && (int'(in_ch) < CHANNELS);

  // Stage 2 math; the true sum always fits SUM_W, so modular arithmetic is exact.
  always_comb begin
    full   = (s1_fill_q == FILL_W'(N));
    sum_d  = s1_sum_q + SUM_W'(s1_data_q) - (full ? SUM_W'(s1_old_q) : '0);
    fill_d = full ? s1_fill_q : s1_fill_q + 1'b1;
    ptr_d  = s1_ptr_q + 1'b1;
  end

  // Stage 1 read; a same-channel sample one stage ahead has not committed yet, so forward it.
  always_comb begin
    fwd     = s1_vld_q && (s1_ch_q == s0_ch_q);
    rd_sum  = fwd ? sum_d  : sum_q[s0_ch_q];
    rd_fill = fwd ? fill_d : fill_q[s0_ch_q];
    rd_ptr  = fwd ? ptr_d  : wptr_q[s0_ch_q];
    rd_old  = hist_q[{s0_ch_q, rd_ptr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NSLOT; c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
      end
      primed_q    <= '0;
      s0_vld_q    <= 1'b0;
      s0_mode_q   <= 1'b0;
      s0_ch_q     <= '0;
      s0_data_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_ch_q     <= '0;
      s1_data_q   <= '0;
      s1_old_q    <= '0;
      s1_sum_q    <= '0;
      s1_fill_q   <= '0;
      s1_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else if (clear) begin
      for (int c = 0; c < NSLOT; c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
      end
      primed_q    <= '0;
      s0_vld_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s0_vld_q  <= accept;
      s0_ch_q   <= in_ch;
      s0_data_q <= in_data;
      s0_mode_q <= mode;

      s1_vld_q  <= s0_vld_q;
      s1_ch_q   <= s0_ch_q;
      s1_data_q <= s0_data_q;
      s1_mode_q <= s0_mode_q;
      s1_sum_q  <= rd_sum;
      s1_fill_q <= rd_fill;
      s1_ptr_q  <= rd_ptr;
      s1_old_q  <= rd_old;

      out_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        sum_q[s1_ch_q]  <= sum_d;
        fill_q[s1_ch_q] <= fill_d;
        wptr_q[s1_ch_q] <= ptr_d;
        if (fill_d == FILL_W'(N)) primed_q[s1_ch_q] <= 1'b1;
        out_ch_q   <= s1_ch_q;
        out_data_q <= s1_mode_q ? s1_data_q : sum_d[SUM_W-1:LOG2_SAMPLES];
      end
    end
  end

  // History is never reset; the fill count keeps stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (s1_vld_q && !clear) hist_q[{s1_ch_q, s1_ptr_q}] <= s1_data_q;
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_analog_filter_mc.sv
// Directed bench for analog_filter_mc (4 channels, 12-bit, N=4) plus a 3-channel
// instance used to present an out-of-range channel number.
module tb_analog_filter_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [11:0] in_data;
  logic        mode;
  logic        clear;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [11:0] out_data;
  logic [3:0]  primed;
  logic        out_valid3;
  logic [1:0]  out_ch3;
  logic [11:0] out_data3;
  logic [2:0]  primed3;

  always #5 clk = ~clk;

  analog_filter_mc #(.CHANNELS(4), .DATA_W(12), .LOG2_SAMPLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .mode(mode), .clear(clear), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .primed(primed)
  );

  analog_filter_mc #(.CHANNELS(3), .DATA_W(12), .LOG2_SAMPLES(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .mode(mode), .clear(clear), .out_valid(out_valid3), .out_ch(out_ch3),
    .out_data(out_data3), .primed(primed3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Expected result of each driven cycle, delayed two cycles to line up with the output.
  bit    ev  [3];
  int    ech [3];
  int    ed  [3];
  string et  [3];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic flush_exp();
    for (int i = 0; i < 3; i++) begin
      ev[i] = 1'b0; ech[i] = 0; ed[i] = 0; et[i] = "none";
    end
  endtask

  // Called at a falling edge: drive one cycle, then check the output due now.
  task automatic cyc(input bit v, input int ch, input int d, input bit md, input bit clr,
                     input bit xv, input int xd, input string tag);
    in_valid = v;
    in_ch    = ch[1:0];
    in_data  = d[11:0];
    mode     = md;
    clear    = clr;
    for (int i = 2; i > 0; i--) begin
      ev[i] = ev[i-1]; ech[i] = ech[i-1]; ed[i] = ed[i-1]; et[i] = et[i-1];
    end
    ev[0] = xv; ech[0] = ch; ed[0] = xd; et[0] = tag;
    @(negedge clk);
    check({et[2], ".valid"}, int'(out_valid), int'(ev[2]));
    if (ev[2]) begin
      check({et[2], ".ch"}, int'(out_ch), ech[2]);
      check({et[2], ".data"}, int'(out_data), ed[2]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, "idle");
  endtask

  int t1d [5] = '{100, 200, 300, 400, 500};
  int t1e [5] = '{25, 75, 150, 250, 350};
  int t2e [6] = '{1023, 2047, 3071, 4095, 4095, 4095};
  int t2bd[6] = '{10, 20, 30, 40, 50, 60};
  int t2be[6] = '{2, 7, 15, 25, 35, 45};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0; mode = 1'b0; clear = 1'b0;
    flush_exp();
    @(negedge clk);
    check("rst.valid", int'(out_valid), 0);
    check("rst.data", int'(out_data), 0);
    check("rst.primed", int'(primed), 0);
    rst_n = 1'b1;

    // ch0 spaced samples; primed rises with the 4th output
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 0, t1d[i], 1'b0, 1'b0, 1'b1, t1e[i], $sformatf("t1_%0d", i));
      idle(2);
      if (i == 2) check("t1.primed_before", int'(primed), 0);
      if (i == 3) check("t1.primed_after", int'(primed), 1);
    end

    // clear with a ch0 sample in flight: suppressed, primed dropped, output held
    cyc(1'b1, 0, 600, 1'b0, 1'b0, 1'b0, 0, "t4_cancel");
    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, "t4_clear");
    check("t4.primed", int'(primed), 0);
    idle(2);
    check("t4.hold", int'(out_data), 350);
    cyc(1'b1, 0, 40, 1'b0, 1'b0, 1'b1, 10, "t4_first");
    idle(2);

    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, "clr");
    // full-scale same-channel burst
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 2, 4095, 1'b0, 1'b0, 1'b1, t2e[i], $sformatf("t2_%0d", i));
    idle(2);
    // varying same-channel burst exercises forwarding of the oldest entry
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 3, t2bd[i], 1'b0, 1'b0, 1'b1, t2be[i], $sformatf("t2b_%0d", i));
    idle(2);

    cyc(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0, "clr");
    check("clr.primed", int'(primed), 0);
    // interleaved ch0/ch1
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 0, 8, 1'b0, 1'b0, 1'b1, 2 * (i + 1), $sformatf("t3_ch0_%0d", i));
      cyc(1'b1, 1, 40, 1'b0, 1'b0, 1'b1, 10 * (i + 1), $sformatf("t3_ch1_%0d", i));
    end
    idle(2);
    check("t3.primed", int'(primed), 3);

    // bypass then average on ch3
    cyc(1'b1, 3, 12'h5A5, 1'b1, 1'b0, 1'b1, 12'h5A5, "t5_byp0");
    cyc(1'b1, 3, 12'h010, 1'b1, 1'b0, 1'b1, 12'h010, "t5_byp1");
    cyc(1'b1, 3, 12'h000, 1'b0, 1'b0, 1'b1, 12'h16D, "t5_avg");
    idle(2);
    check("t5.primed", int'(primed), 3);

    // asynchronous reset mid-stream with a sample in flight and one presented
    cyc(1'b1, 0, 123, 1'b0, 1'b0, 1'b0, 0, "t6_inflight");
    rst_n = 1'b0;
    in_valid = 1'b1; in_ch = 2'd2; in_data = 12'd999;
    #1;
    check("t6.valid", int'(out_valid), 0);
    check("t6.ch", int'(out_ch), 0);
    check("t6.data", int'(out_data), 0);
    check("t6.primed", int'(primed), 0);
    flush_exp();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    cyc(1'b1, 1, 400, 1'b0, 1'b0, 1'b1, 100, "t6_first");
    idle(2);

    // ch3 is out of range for the 3-channel instance, in range for the main one
    cyc(1'b1, 3, 80, 1'b0, 1'b0, 1'b1, 20, "t7_oor");
    check("t7.oor_v0", int'(out_valid3), 0);
    idle(1);
    check("t7.oor_v1", int'(out_valid3), 0);
    idle(1);
    check("t7.oor_v2", int'(out_valid3), 0);
    cyc(1'b1, 2, 80, 1'b0, 1'b0, 1'b1, 20, "t7_inr");
    idle(2);
    check("t7.inr_valid3", int'(out_valid3), 1);
    check("t7.inr_data3", int'(out_data3), 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
